// File: rtl/lock_password_multi_pkg.sv
// lock_password_multi_pkg: shared state encoding and counter-width helper for the password lock
package lock_password_multi_pkg;
  typedef enum logic [2:0] {S_IDLE, S_OPEN, S_PROG, S_ERR, S_LOCK} state_t;
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/lock_password_multi_if.sv
// lock_password_multi_if: button, code and indicator signals of the password lock
interface lock_password_multi_if #(parameter int DW = 4);
  logic enter_n;
  logic press_n;
  logic mode;
  logic [DW-1:0] code;
  logic open;
  logic error;
  logic locked;
  logic [3:0] dcount;
  modport master (output enter_n, press_n, mode, code, input open, error, locked, dcount);
  modport slave (input enter_n, press_n, mode, code, output open, error, locked, dcount);
endinterface

// File: rtl/lock_password_multi_key_cond.sv
// lock_key_cond: synchronises and debounces one active-low button, pulsing once per accepted press
module lock_key_cond
  import lock_password_multi_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pulse
);
  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic s1, s2, level, hit;
  logic [CW-1:0] cnt;
  // a new level is accepted after it differed from the held level for DEBOUNCE_CYCLES samples
  assign hit = (s2 != level) && (cnt == C_LAST);
  assign pulse = hit && !s2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      level <= 1'b1;
      cnt <= '0;
    end else begin
      s1 <= key_n;
      s2 <= s1;
      cnt <= (s2 == level || hit) ? '0 : cnt + CW'(1);
      level <= hit ? s2 : level;
    end
endmodule

// File: rtl/lock_password_multi.sv
// lock_password_multi: multi-digit password lock with re-programming, timed open/error and lockout
module lock_password_multi
  import lock_password_multi_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DW = 4,
  parameter logic [DIGITS*DW-1:0] DEFAULT_PW = 16'h1234,
  parameter int OPEN_CYCLES = 50000000,
  parameter int ERROR_CYCLES = 25000000,
  parameter int MAX_FAIL = 3,
  parameter int LOCKOUT_CYCLES = 500000000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input logic clk,
  input logic rst_n,
  lock_password_multi_if.slave bus
);
  localparam int PW = DIGITS * DW;
  localparam int TW = cnt_w(LOCKOUT_CYCLES);
  localparam int FW = cnt_w(MAX_FAIL);
  localparam logic [TW-1:0] T_OPEN = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] T_ERR = TW'(ERROR_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCK = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_ERRN = TW'(ERROR_CYCLES);
  localparam logic [FW-1:0] F_MAX = FW'(MAX_FAIL);
  localparam logic [3:0] D_MAX = 4'(DIGITS);
  state_t state, state_n;
  logic [PW-1:0] dbuf, dbuf_n, pw, pw_n, shifted;
  logic [3:0] dcount, dcount_n;
  logic [FW-1:0] fail, fail_n, fail_inc;
  logic [TW-1:0] timer, timer_n;
  logic perr, perr_n, enter_p, press_p, press_ok, full, match;
  lock_key_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (.clk(clk), .rst_n(rst_n), .key_n(bus.enter_n), .pulse(enter_p));
  lock_key_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_press (.clk(clk), .rst_n(rst_n), .key_n(bus.press_n), .pulse(press_p));
  assign press_ok = press_p && !enter_p;
  assign full = dcount == D_MAX;
  assign match = full && dbuf == pw;
  assign shifted = PW'({dbuf, bus.code});
  assign fail_inc = (fail == F_MAX) ? fail : fail + FW'(1);
  assign bus.dcount = dcount;
  always_comb begin
    state_n = state;
    dbuf_n = dbuf;
    dcount_n = dcount;
    pw_n = pw;
    fail_n = fail;
    perr_n = perr;
    case (state)
      S_IDLE:
        if (enter_p) begin
          dbuf_n = '0;
          dcount_n = '0;
          fail_n = match ? '0 : fail_inc;
          state_n = match ? S_OPEN : (fail_inc == F_MAX ? S_LOCK : S_ERR);
        end else if (press_ok && !full) begin
          dbuf_n = shifted;
          dcount_n = dcount + 4'd1;
        end
      S_OPEN:
        if (press_ok && bus.mode) begin
          dbuf_n = shifted;
          dcount_n = dcount + 4'd1;
          perr_n = 1'b0;
          state_n = S_PROG;
        end else if (timer == T_OPEN) begin
          perr_n = 1'b0;
          state_n = S_IDLE;
        end
      S_PROG:
        if (enter_p) begin
          dbuf_n = '0;
          dcount_n = '0;
          pw_n = full ? dbuf : pw;
          perr_n = !full;
          state_n = S_OPEN;
        end else if (press_ok && !full) begin
          dbuf_n = shifted;
          dcount_n = dcount + 4'd1;
        end
      S_ERR: state_n = (timer == T_ERR) ? S_IDLE : S_ERR;
      S_LOCK:
        if (timer == T_LOCK) begin
          state_n = S_IDLE;
          fail_n = '0;
        end
      default: state_n = S_IDLE;
    endcase
  end
  // one shared timer: cleared on every state entry, idle in IDLE and frozen in PROG
  assign timer_n = (state_n != state || state == S_IDLE || state == S_PROG) ? '0 : timer + TW'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      dbuf <= '0;
      dcount <= '0;
      pw <= DEFAULT_PW;
      fail <= '0;
      perr <= 1'b0;
      timer <= '0;
      bus.open <= 1'b0;
      bus.error <= 1'b0;
      bus.locked <= 1'b0;
    end else begin
      state <= state_n;
      dbuf <= dbuf_n;
      dcount <= dcount_n;
      pw <= pw_n;
      fail <= fail_n;
      perr <= perr_n;
      timer <= timer_n;
      bus.open <= state_n == S_OPEN || state_n == S_PROG;
      // a short programming attempt flags ERROR for the first ERROR_CYCLES of the following OPEN
      bus.error <= state_n == S_ERR || state_n == S_LOCK || (state_n == S_OPEN && perr_n && timer_n < T_ERRN);
      bus.locked <= state_n == S_LOCK;
    end
endmodule
